// File: rtl/rv32i_types.sv
// rv32i_types
//   Shared RV32 type definitions for the execute stage.
//   Contents:
//     muldiv_funct3_t - RV32M funct3 encodings (mul .. remu)
//     muldiv_state_t  - sequencing states of the multiply/divide unit
//     OP_REG_FUNCT7   - funct7 value that selects the M extension in OP-format decode
//     isDivOp         - true for the four divide/remainder encodings
package rv32i_types;

    typedef enum logic [2:0] {
        mul    = 3'd0,
        mulh   = 3'd1,
        mulhsu = 3'd2,
        mulhu  = 3'd3,
        div    = 3'd4,
        divu   = 3'd5,
        rem    = 3'd6,
        remu   = 3'd7
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam logic [6:0] OP_REG_FUNCT7 = 7'b0000001;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic isDivOp(input muldiv_funct3_t f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_datapath_step.sv
// muldiv_datapath_step
//   Combinational single iteration of the multiply/divide datapath, retiring
//   BITS_PER_CYCLE bits per call.
//   Ports:
//     isDiv_i   - 1: restoring-divide step, 0: shift-add multiply step
//     acc_i/o   - multiply: {partial product high, remaining multiplier bits}
//                 divide:   low XLEN bits hold dividend bits shifting out / quotient bits shifting in
//     rem_i/o   - divide partial remainder (always smaller than the divisor between steps)
//     operand_i - multiplicand (multiply) or divisor (divide), both as magnitudes
module muldiv_datapath_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              isDiv_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   rem_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   rem_o
);

    // The shifted partial remainder can reach 2*divisor-1, so it needs one
    // extra bit before the trial subtraction; after restoring it fits in XLEN.
    always_comb begin
        logic [2*XLEN-1:0] acc;
        logic [XLEN:0]     remWide;
        logic [XLEN:0]     trial;
        logic [XLEN:0]     sum;
        acc     = acc_i;
        remWide = {1'b0, rem_i};
        trial   = '0;
        sum     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (isDiv_i) begin
                remWide = {remWide[XLEN-1:0], acc[XLEN-1]};
                trial   = remWide - {1'b0, operand_i};
                acc[XLEN-1:0] = {acc[XLEN-2:0], ~trial[XLEN]};
                if (!trial[XLEN]) begin
                    remWide = trial;
                end
            end else begin
                sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_i} : '0);
                acc = {sum, acc[XLEN-1:1]};
            end
        end
        acc_o = acc;
        rem_o = remWide[XLEN-1:0];
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit beside the execute-stage ALU.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     start      - request valid, only sampled in IDLE
//     op         - RV32M funct3
//     a, b       - forwarded rs1 / rs2 values
//     hold       - downstream stall, keeps a finished result in DONE
//     flush      - kills the operation in flight
//     stall_req  - execute stage must hold its pipeline registers
//     done       - result valid
//     result     - registered result
module ex_muldiv_unit
    import rv32i_types::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hold,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    muldiv_state_t     state_q, state_d;
    muldiv_funct3_t    op_q, opIn;
    logic              negResult_q, negRem_q;
    logic [CNT_W-1:0]  counter_q;
    logic [2*XLEN-1:0] acc_q, stepAcc;
    logic [XLEN-1:0]   rem_q, stepRem;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              aSigned, bSigned, signA, signB;
    logic [XLEN-1:0]   aMag, bMag;
    logic              divByZero, divOverflow, specialCase;
    logic [XLEN-1:0]   specialResult;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder, fixResult;

    assign opIn   = muldiv_funct3_t'(op);
    assign accept = (state_q == IDLE) && start && !flush;

    // MUL is taken as unsigned: the low word of the product does not depend
    // on operand signedness, so the sign correction would be wasted work.
    assign aSigned = (opIn == mulh) || (opIn == mulhsu) || (opIn == div) || (opIn == rem);
    assign bSigned = (opIn == mulh) || (opIn == div) || (opIn == rem);
    assign signA   = aSigned && a[XLEN-1];
    assign signB   = bSigned && b[XLEN-1];
    assign aMag    = signA ? -a : a;
    assign bMag    = signB ? -b : b;

    assign divByZero   = isDivOp(opIn) && (b == '0);
    assign divOverflow = ((opIn == div) || (opIn == rem)) &&
                         (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign specialCase = divByZero || divOverflow;

    // funct3[1] set means a remainder op within the divide family
    always_comb begin
        specialResult = '0;
        if (divByZero) begin
            specialResult = op[1] ? a : '1;
        end else if (divOverflow) begin
            specialResult = op[1] ? '0 : a;
        end
    end

    assign product   = negResult_q ? -acc_q : acc_q;
    assign quotient  = negResult_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign remainder = negRem_q ? -rem_q : rem_q;

    always_comb begin
        fixResult = '0;
        case (op_q)
            mul:                  fixResult = product[XLEN-1:0];
            mulh, mulhsu, mulhu:  fixResult = product[2*XLEN-1:XLEN];
            div, divu:            fixResult = quotient;
            rem, remu:            fixResult = remainder;
            default:              fixResult = '0;
        endcase
    end

    muldiv_datapath_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .isDiv_i   (isDivOp(op_q)),
        .acc_i     (acc_q),
        .rem_i     (rem_q),
        .operand_i (operand_q),
        .acc_o     (stepAcc),
        .rem_o     (stepRem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter is checked before its decrement, so a value of 1 marks the
    // last RUN iteration; flush beats hold everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = specialCase ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (counter_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = flush ? IDLE : DONE;
            end
            DONE: begin
                if (flush || !hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:    stall_req = start && !flush;
            RUN:     stall_req = 1'b1;
            FIX:     stall_req = 1'b1;
            DONE:    done      = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    // Multiply keeps the multiplier in the low half of the accumulator so it
    // shifts out as the product shifts in; divide keeps the dividend there so
    // quotient bits replace it. operand_q holds multiplicand or divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= mul;
            negResult_q <= 1'b0;
            negRem_q    <= 1'b0;
            counter_q   <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            operand_q   <= '0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= opIn;
                        negResult_q <= signA ^ signB;
                        negRem_q    <= signA;
                        counter_q   <= CNT_W'(STEPS);
                        rem_q       <= '0;
                        if (specialCase) begin
                            result_q <= specialResult;
                        end else if (isDivOp(opIn)) begin
                            operand_q <= bMag;
                            acc_q     <= {{XLEN{1'b0}}, aMag};
                        end else begin
                            operand_q <= aMag;
                            acc_q     <= {{XLEN{1'b0}}, bMag};
                        end
                    end
                end
                RUN: begin
                    acc_q     <= stepAcc;
                    rem_q     <= stepRem;
                    counter_q <= counter_q - CNT_W'(1);
                end
                FIX: begin
                    if (!flush) begin
                        result_q <= fixResult;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
//   Directed bench for ex_muldiv_unit. Two instances (one bit and four bits
//   per cycle) are exercised one after the other with the same suite; the
//   idle instance sits with all inputs low.
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic            startV [2];
    logic [2:0]      opV    [2];
    logic [XLEN-1:0] aV     [2];
    logic [XLEN-1:0] bV     [2];
    logic            holdV  [2];
    logic            flushV [2];
    logic            stallV [2];
    logic            doneV  [2];
    logic [XLEN-1:0] resV   [2];

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    int normLat;

    ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(startV[0]), .op(opV[0]), .a(aV[0]), .b(bV[0]),
        .hold(holdV[0]), .flush(flushV[0]), .stall_req(stallV[0]), .done(doneV[0]),
        .result(resV[0])
    );

    ex_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(startV[1]), .op(opV[1]), .a(aV[1]), .b(bV[1]),
        .hold(holdV[1]), .flush(flushV[1]), .stall_req(stallV[1]), .done(doneV[1]),
        .result(resV[1])
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (dut bpc=%0d): observed 0x%08h expected 0x%08h",
                     tag, (sel == 0) ? 1 : 4, observed, expected);
        end
    endtask

    // Counts edges from the accepting edge (counted as 1) until done is seen.
    task automatic waitDone(output int cyc);
        cyc = 1;
        while (doneV[sel] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge,
    // with the operand inputs scrambled to prove they were latched.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        opV[sel]    = op;
        aV[sel]     = a;
        bV[sel]     = b;
        startV[sel] = 1'b1;
        #1;
        checkOutput("stall_accept", 32'(stallV[sel]), 32'd1);
        @(negedge clk);
        startV[sel] = 1'b0;
        aV[sel]     = ~a;
        bV[sel]     = ~b;
        opV[sel]    = ~op;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        int cyc;
        applyStimulus(op, a, b);
        waitDone(cyc);
        checkOutput({tag, "_lat"}, 32'(cyc), 32'(expLat));
        checkOutput(tag, resV[sel], expRes);
        checkOutput({tag, "_stall"}, 32'(stallV[sel]), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_doneclr"}, 32'(doneV[sel]), 32'd0);
    endtask

    task automatic runSuite();
        int  cyc;
        logic sawDone;
        normLat = (sel == 0) ? 34 : 10;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_done", 32'(doneV[sel]), 32'd0);
        checkOutput("rst_result", resV[sel], 32'd0);
        checkOutput("rst_stall", 32'(stallV[sel]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp("mul",    OP_MUL,   32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, normLat);
        runOp("mulh",   OP_MULH,  32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, normLat);
        runOp("mulhu",  OP_MULHU, 32'd7, 32'hFFFFFFFD, 32'h00000006, normLat);
        runOp("div",    OP_DIV,   32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, normLat);
        runOp("rem",    OP_REM,   32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, normLat);
        runOp("divu",   OP_DIVU,  32'd20, 32'd6, 32'd3, normLat);
        runOp("remu",   OP_REMU,  32'd20, 32'd6, 32'd2, normLat);
        runOp("div0",   OP_DIV,   32'd5, 32'd0, 32'hFFFFFFFF, 1);
        runOp("rem0",   OP_REM,   32'd5, 32'd0, 32'd5, 1);
        runOp("divu0",  OP_DIVU,  32'd5, 32'd0, 32'hFFFFFFFF, 1);
        runOp("divovf", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp("removf", OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        runOp("divubig", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, normLat);
        runOp("remubig", OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, normLat);

        // hold keeps the result; a start offered while leaving DONE waits for IDLE
        holdV[sel] = 1'b1;
        applyStimulus(OP_MULHU, 32'd7, 32'hFFFFFFFD);
        waitDone(cyc);
        checkOutput("hold_lat", 32'(cyc), 32'(normLat));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_done", 32'(doneV[sel]), 32'd1);
            checkOutput("hold_result", resV[sel], 32'h00000006);
            checkOutput("hold_stall", 32'(stallV[sel]), 32'd0);
        end
        holdV[sel]  = 1'b0;
        opV[sel]    = OP_MUL;
        aV[sel]     = 32'd7;
        bV[sel]     = 32'hFFFFFFFD;
        startV[sel] = 1'b1;
        @(negedge clk);
        checkOutput("hold_release_done", 32'(doneV[sel]), 32'd0);
        checkOutput("hold_release_stall", 32'(stallV[sel]), 32'd1);
        @(negedge clk);
        startV[sel] = 1'b0;
        aV[sel]     = 32'd0;
        waitDone(cyc);
        checkOutput("restart_lat", 32'(cyc), 32'(normLat));
        checkOutput("restart_result", resV[sel], 32'hFFFFFFEB);
        @(negedge clk);

        // flush mid-RUN: back to IDLE, result untouched, done never rises
        applyStimulus(OP_DIVU, 32'd20, 32'd6);
        for (int i = 1; i < ((sel == 0) ? 10 : 5); i++) @(negedge clk);
        flushV[sel] = 1'b1;
        #1;
        checkOutput("flush_run_stall", 32'(stallV[sel]), 32'd1);
        @(negedge clk);
        flushV[sel] = 1'b0;
        checkOutput("flush_stall", 32'(stallV[sel]), 32'd0);
        checkOutput("flush_result", resV[sel], 32'hFFFFFFEB);
        sawDone = 1'b0;
        for (int i = 0; i < normLat + 4; i++) begin
            @(negedge clk);
            if (doneV[sel] === 1'b1) sawDone = 1'b1;
        end
        checkOutput("flush_no_done", 32'(sawDone), 32'd0);
        runOp("mulhsu", OP_MULHSU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, normLat);

        // flush in IDLE blocks acceptance
        opV[sel]    = OP_MUL;
        aV[sel]     = 32'd3;
        bV[sel]     = 32'd3;
        startV[sel] = 1'b1;
        flushV[sel] = 1'b1;
        #1;
        checkOutput("flush_idle_stall", 32'(stallV[sel]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        startV[sel] = 1'b0;
        flushV[sel] = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < normLat + 4; i++) begin
            @(negedge clk);
            if (doneV[sel] === 1'b1) sawDone = 1'b1;
        end
        checkOutput("flush_idle_no_done", 32'(sawDone), 32'd0);
        checkOutput("flush_idle_result", resV[sel], 32'hFFFFFFFE);

        // reset at RUN cycle 5 clears everything
        applyStimulus(OP_MUL, 32'd7, 32'hFFFFFFFD);
        for (int i = 1; i < 5; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_run_done", 32'(doneV[sel]), 32'd0);
        checkOutput("rst_run_result", resV[sel], 32'd0);
        checkOutput("rst_run_stall", 32'(stallV[sel]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        runOp("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, normLat);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            startV[i] = 1'b0;
            opV[i]    = 3'd0;
            aV[i]     = '0;
            bV[i]     = '0;
            holdV[i]  = 1'b0;
            flushV[i] = 1'b0;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            $display("[TB] suite for bits-per-cycle %0d", (s == 0) ? 1 : 4);
            runSuite();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage.
- Accepts one operation per request and returns a registered result after a fixed, parametrised number of cycles.
- Asserts a stall request so the execute stage holds its pipeline registers while the unit works.
- Honours downstream hold (memory stall) and branch-flush.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; must divide XLEN (legal 1, 2, 4).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request valid; sampled only in IDLE
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  XLEN  rs1 value, already forwarded
- b  input  XLEN  rs2 value, already forwarded
- hold  input  1  downstream stall; result must be held
- flush  input  1  kill the in-flight operation
- stall_req  output  1  execute stage must not advance
- done  output  1  result valid
- result  output  XLEN  registered result

Behaviour:
- States: IDLE, RUN, FIX, DONE.
- Reset: state IDLE; done=0; result=0; iteration counter, accumulator and operand registers cleared. rst overrides everything, including mid-RUN.
- IDLE, start=1, normal operation:
  - Latch op and sign flags.
  - Latch operand magnitudes: signed operands are two's-complement negated when negative. MULHSU treats a as signed and b as unsigned.
  - Load counter with XLEN/BITS_PER_CYCLE, then go to RUN.
- IDLE, start=1, special divide cases (go straight to DONE next cycle, no RUN):
  - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - DIV/REM with a = most-negative and b = -1: DIV = a; REM = 0.
- RUN:
  - Multiply: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle, with partial remainder of XLEN+1 bits.
  - Counter decrements each cycle; at 0 go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Product negated if signs differ. Quotient negated if signs differ. Remainder takes the sign of a.
  - Select the output word: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU the quotient; REM/REMU the remainder.
  - Register into result and go to DONE.
- Latency, start to done (BITS_PER_CYCLE=1, XLEN=32): 34 cycles normal (1 accept + 32 RUN + 1 FIX), 1 cycle for the special cases.
- DONE:
  - done=1 and result stable.
  - hold=1: stay in DONE.
  - hold=0: go to IDLE next cycle; done falls with it.
  - A new start is not accepted in the same cycle DONE is left; it is sampled next cycle in IDLE.
- stall_req (combinational):
  - 1 when (IDLE and start and not flush), or in RUN, or in FIX.
  - 0 in DONE, so the pipeline advances exactly when the result is valid and hold=0.
- flush:
  - In any state except IDLE: next state IDLE, done=0, result unchanged.
  - In IDLE it suppresses acceptance of start and forces stall_req=0.
  - flush has priority over hold.
- start while not IDLE: ignored. Inputs a, b and op may change freely after the accept cycle.
- Arithmetic is unsigned on magnitudes. No overflow exceptions; results wrap per RV32M.

Decomposition:
- Package rv32i_types gains:
  - muldiv_funct3_t enum (mul..remu);
  - muldiv_state_t enum (IDLE, RUN, FIX, DONE);
  - constant op_reg funct7 value 7'b0000001 for decode.
- One sub-module: muldiv_datapath_step, the combinational single-iteration shift-add / restore-subtract step for BITS_PER_CYCLE bits. It is instantiated once; the FSM and registers remain in ex_muldiv_unit.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at cycle 34, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-20, b=6 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFE (-2); DIVU a=20, b=6 -> 3; REMU -> 2.
- DIV a=5, b=0 -> done after 1 cycle, result 0xFFFFFFFF; REM -> 5. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- hold=1 asserted from done for 5 cycles -> done stays 1, result stable, stall_req=0; hold drops -> done=0 next cycle, new start accepted the cycle after.
- flush at RUN cycle 10 -> IDLE next cycle, done never rises, result keeps its previous value; new MULHSU a=-2, b=0xFFFFFFFF -> 0xFFFFFFFE.
- rst at RUN cycle 5 -> all outputs 0 next cycle. Repeat the suite with BITS_PER_CYCLE=4 -> normal latency 10 cycles, identical results.
